imem_program_loader: RTL and testbench

Writer-side counterpart of the CPU instruction fetch path. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words, and writes them into instruction memory from address 0 through a single write port. It then fills every remaining word with the NOP encoding. While loading, it holds the CPU pipeline in reset, so benches and boot logic never poke memory hierarchically.

---
 rtl/imem_program_loader.sv | 110 +++++++++++
 tb/tb_imem_program_loader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// imem_program_loader: assembles a byte stream into instruction words, NOP-fills the rest of imem, and holds the CPU in reset until the load completes
module imem_program_loader #(
    parameter int          ADDR_WIDTH = 10,
    parameter logic [31:0] NOP_WORD   = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   prog_len,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    output logic [31:0]           imem_wdata,
    output logic                  cpu_reset_hold,
    output logic                  busy,
    output logic                  done,
    output logic                  len_error
);
    localparam logic [ADDR_WIDTH:0] DEPTH_W = {1'b1, {ADDR_WIDTH{1'b0}}};
    typedef enum logic [2:0] {IDLE, RECV, WRITE, FILL, DONE} state_t;
    state_t state, state_n;
    logic [ADDR_WIDTH:0] len, word_ptr;
    logic [1:0] byte_idx;
    logic [31:0] word;
    logic loaded, xfer, kill, fill_last;
    // handshake and control decodes; s_ready is the only combinational output
    always_comb begin
        s_ready   = state == RECV;
        xfer      = s_valid && s_ready;
        kill      = abort && state != IDLE;
        fill_last = word_ptr[ADDR_WIDTH] || &word_ptr[ADDR_WIDTH-1:0];
    end
    // next-state logic; abort outside IDLE overrides every transition
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? (prog_len == '0 ? FILL : RECV) : IDLE;
            RECV:    state_n = xfer && byte_idx == 2'd3 ? WRITE : RECV;
            WRITE:   state_n = word_ptr + 1'b1 == len ? FILL : RECV;
            FILL:    state_n = fill_last ? DONE : FILL;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (kill) state_n = IDLE;
    end
    // state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else state <= state_n;
    end
    // datapath and registered outputs; a memory write appears on the bus the cycle after WRITE/FILL decides it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_we        <= 1'b0;
            imem_addr      <= '0;
            imem_wdata     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            len_error      <= 1'b0;
            loaded         <= 1'b0;
            cpu_reset_hold <= 1'b1;
            byte_idx       <= '0;
            word_ptr       <= '0;
            len            <= '0;
            word           <= '0;
        end else begin
            imem_we        <= 1'b0;
            done           <= state == DONE && !kill;
            busy           <= state_n inside {RECV, WRITE, FILL};
            cpu_reset_hold <= ~loaded;
            if (kill) begin
                byte_idx <= '0;
                word_ptr <= '0;
                loaded   <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        len       <= prog_len > DEPTH_W ? DEPTH_W : prog_len;
                        len_error <= prog_len > DEPTH_W;
                        loaded    <= 1'b0;
                    end
                    RECV: if (xfer) begin
                        word[{byte_idx, 3'b000} +: 8] <= s_data;
                        byte_idx                      <= byte_idx + 1'b1;
                    end
                    WRITE: begin
                        imem_we    <= 1'b1;
                        imem_addr  <= word_ptr[ADDR_WIDTH-1:0];
                        imem_wdata <= word;
                        word_ptr   <= word_ptr + 1'b1;
                    end
                    FILL: if (!word_ptr[ADDR_WIDTH]) begin
                        imem_we    <= 1'b1;
                        imem_addr  <= word_ptr[ADDR_WIDTH-1:0];
                        imem_wdata <= NOP_WORD;
                        word_ptr   <= word_ptr + 1'b1;
                    end
                    DONE: begin
                        loaded   <= 1'b1;
                        word_ptr <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_imem_program_loader.sv
// tb_imem_program_loader: randomized loads checked against an expected memory image built from the byte stream
module tb_imem_program_loader;
    localparam int AW = 10;
    localparam int DEPTH = 1 << AW;
    localparam int NB = 4 * DEPTH + 16;
    localparam logic [31:0] NOP = 32'h00000013;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, abort = 1'b0, s_valid = 1'b0;
    logic [AW:0] prog_len = '0;
    logic [7:0] s_data = '0;
    logic s_ready, imem_we, cpu_reset_hold, busy, done, len_error;
    logic [AW-1:0] imem_addr;
    logic [31:0] imem_wdata;
    logic [7:0] stream [NB];
    logic [41:0] wq [$];
    int total = 0, bad = 0, cyc = 0, nbytes = 0, ndone = 0, nready = 0, ready_viol = 0;
    logic prev_ready = 1'b0;

    imem_program_loader #(.ADDR_WIDTH(AW), .NOP_WORD(NOP)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .prog_len(prog_len),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready), .imem_we(imem_we),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .cpu_reset_hold(cpu_reset_hold),
        .busy(busy), .done(done), .len_error(len_error)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // bus monitor: writes, accepted bytes, ready cycles, done pulses; a write must never follow a ready cycle
    always @(negedge clk) begin
        if (imem_we) begin
            wq.push_back({imem_addr, imem_wdata});
            if (prev_ready) ready_viol <= ready_viol + 1;
        end
        if (s_valid && s_ready) nbytes <= nbytes + 1;
        if (s_ready) nready <= nready + 1;
        if (done) ndone <= ndone + 1;
        prev_ready <= s_ready;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input int i);
        return {stream[4*i+3], stream[4*i+2], stream[4*i+1], stream[4*i]};
    endfunction

    task automatic randomize_stream();
        for (int i = 0; i < NB; i++) stream[i] = 8'($urandom);
    endtask

    // expected image: words 0..L-1 come from the stream in order, the rest are NOPs, one write per address
    task automatic verify_image(input string tag, input int plen, input int b_wq);
        int l = plen > DEPTH ? DEPTH : plen;
        int n = wq.size() - b_wq;
        int nerr = 0;
        check({tag, "_nwrites"}, n, DEPTH);
        for (int i = 0; i < n && i < DEPTH; i++) begin
            logic [41:0] e;
            e = {i[AW-1:0], i < l ? exp_word(i) : NOP};
            if (wq[b_wq + i] !== e) nerr++;
        end
        check({tag, "_image"}, nerr, 0);
    endtask

    // tiny RV32I interpreter over the written image (addi/add only) to confirm the released CPU result
    task automatic run_cpu(input int b_wq);
        logic [31:0] x [32];
        for (int r = 0; r < 32; r++) x[r] = '0;
        for (int i = 0; i < DEPTH && b_wq + i < wq.size(); i++) begin
            logic [31:0] w;
            w = wq[b_wq + i][31:0];
            if (w[6:0] == 7'h13 && w[14:12] == 3'd0 && w[11:7] != 5'd0)
                x[w[11:7]] = x[w[19:15]] + {{20{w[31]}}, w[31:20]};
            else if (w[6:0] == 7'h33 && w[14:12] == 3'd0 && w[31:25] == 7'd0 && w[11:7] != 5'd0)
                x[w[11:7]] = x[w[19:15]] + x[w[24:20]];
        end
        check("cpu_x3", x[3], 32'h0000000f);
    endtask

    task automatic do_load(input int plen, input int duty, output int lat, output bit ok);
        int idx = 0;
        int acc;
        ok = 1'b0;
        lat = 0;
        @(posedge clk); #1;
        start = 1'b1;
        prog_len = plen[AW:0];
        @(posedge clk); #1;
        start = 1'b0;
        acc = cyc;
        for (int k = 0; k < 12000; k++) begin
            s_valid = idx < NB && $urandom_range(99) < duty;
            s_data = idx < NB ? stream[idx] : 8'h00;
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                lat = cyc - acc;
                break;
            end
            if (s_valid && s_ready) idx++;
            @(posedge clk); #1;
        end
        s_valid = 1'b0;
        check("done_seen", ok, 1);
        if (ok) begin
            check("hold_at_done", cpu_reset_hold, 1);
            @(negedge clk);
            check("hold_after_done", cpu_reset_hold, 0);
            check("done_one_cycle", done, 0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_we"}, imem_we, 0);
        check({tag, "_addr"}, imem_addr, 0);
        check({tag, "_wdata"}, imem_wdata, 0);
        check({tag, "_hold"}, cpu_reset_hold, 1);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_len_err"}, len_error, 0);
    endtask

    initial begin
        logic [7:0] prog [12] = '{8'h93, 8'h00, 8'ha0, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'hb3, 8'h81, 8'h20, 8'h00};
        int lat, b_wq, b_bytes, b_done, b_ready, idx, nerr;
        bit ok;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("idle_hold", cpu_reset_hold, 1);
        check("idle_busy", busy, 0);

        randomize_stream();
        for (int i = 0; i < 12; i++) stream[i] = prog[i];
        for (int pass = 0; pass < 2; pass++) begin
            b_wq = wq.size(); b_bytes = nbytes; b_done = ndone;
            do_load(3, pass == 0 ? 100 : 50, lat, ok);
            verify_image(pass == 0 ? "p3_full" : "p3_half", 3, b_wq);
            run_cpu(b_wq);
            check("p3_bytes", nbytes - b_bytes, 12);
            check("p3_done_cnt", ndone - b_done, 1);
            check("p3_len_err", len_error, 0);
            check("p3_busy_end", busy, 0);
        end

        b_wq = wq.size(); b_bytes = nbytes; b_ready = nready;
        do_load(0, 100, lat, ok);
        verify_image("p0", 0, b_wq);
        check("p0_latency", lat, 1025);
        check("p0_ready_cycles", nready - b_ready, 0);
        check("p0_bytes", nbytes - b_bytes, 0);

        randomize_stream();
        b_wq = wq.size(); b_bytes = nbytes;
        do_load(1100, 100, lat, ok);
        verify_image("p1100", 1100, b_wq);
        check("p1100_len_err", len_error, 1);
        check("p1100_bytes", nbytes - b_bytes, 4 * DEPTH);

        randomize_stream();
        b_wq = wq.size(); b_bytes = nbytes;
        do_load(1, 80, lat, ok);
        verify_image("p1", 1, b_wq);
        check("p1_len_err_clr", len_error, 0);
        check("p1_bytes", nbytes - b_bytes, 4);

        randomize_stream();
        b_wq = wq.size(); b_done = ndone;
        @(posedge clk); #1;
        start = 1'b1;
        prog_len = 11'd3;
        @(posedge clk); #1;
        start = 1'b0;
        idx = 0;
        for (int k = 0; k < 200 && idx < 6; k++) begin
            s_valid = 1'b1;
            s_data = stream[idx];
            @(negedge clk);
            if (s_valid && s_ready) idx++;
            @(posedge clk); #1;
        end
        check("abort_bytes_sent", idx, 6);
        abort = 1'b1;
        s_data = stream[6];
        @(posedge clk); #1;
        abort = 1'b0;
        s_valid = 1'b0;
        check("abort_we_low", imem_we, 0);
        check("abort_busy", busy, 0);
        repeat (20) @(posedge clk);
        #1;
        check("abort_nwrites", wq.size() - b_wq, 1);
        if (wq.size() > b_wq) check("abort_addr0", wq[b_wq], {10'd0, exp_word(0)});
        check("abort_hold", cpu_reset_hold, 1);
        check("abort_no_done", ndone - b_done, 0);
        check("abort_s_ready", s_ready, 0);

        randomize_stream();
        b_wq = wq.size(); b_bytes = nbytes;
        do_load(2, 70, lat, ok);
        verify_image("recover", 2, b_wq);
        check("recover_bytes", nbytes - b_bytes, 8);

        b_wq = wq.size(); b_done = ndone;
        @(posedge clk); #1;
        start = 1'b1;
        prog_len = 11'd0;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        start = 1'b1;
        prog_len = 11'd5;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (50) @(posedge clk);
        #3;
        check("mid_fill_we", imem_we, 1);
        check("mid_fill_s_ready", s_ready, 0);
        nerr = 0;
        for (int j = 0; j < wq.size() - b_wq; j++)
            if (wq[b_wq + j] !== {j[AW-1:0], NOP}) nerr++;
        check("mid_fill_seq", nerr, 0);
        reset = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("post_reset");
        check("reset_no_done", ndone - b_done, 0);
        check("ready_during_write", ready_viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
